// File: rtl/dec_unbinder_pack_4_if.sv
// Bound-HV in / level-HV out bundle for dec_unbinder_pack_4.
// master: HV source/consumer; slave: the unbinder.
interface dec_unbinder_pack_4_if #(
  parameter int HV_DIM = 64,
  parameter int NUM_CH = 10
);
  logic                             start_decoding;
  logic [0:NUM_CH-1][HV_DIM-1:0]    shifted_hv;
  logic [0:NUM_CH-1][HV_DIM-1:0]    level_hv;
  logic                             busy;
  logic                             done;

  modport master (
    output start_decoding, shifted_hv,
    input  level_hv, busy, done
  );

  modport slave (
    input  start_decoding, shifted_hv,
    output level_hv, busy, done
  );
endinterface

// File: rtl/dec_unbinder_pack_4.sv
// Unbinds cyclic-shift-bound level HVs 40..49 (rotate toward lower index).
// Ports: clk, nrst (async active-low), bus (slave modport:
// start_decoding, shifted_hv in; level_hv, busy, done out).
// Build option DEC_UNBINDER_PARALLEL_EN: one rotator per channel,
// all channels written in a single UNBIND cycle.
package dec_unbinder_pkg;
  localparam int HV_DIM     = 64;
  localparam int NUM_SHIFTS = 50;
  localparam int SHIFTS [NUM_SHIFTS] = '{
    3,   5,   7,  11,  13,  17,  19,  23,  29,  31,
    37,  41,  43,  47,  53,  59,  61,  67,  71,  73,
    79,  83,  89,  97, 101, 103, 107, 109, 113, 127,
    2,   4,   6,   8,  10,  12,  14,  16,  18,  20,
    0,   1,  63,  64,  65,  17, 130,  33,   7, 200
  };
endpackage

module dec_unbinder_pack_4 #(
  parameter int HV_DIM     = dec_unbinder_pkg::HV_DIM,
  parameter int NUM_CH     = 10,
  parameter int SHIFT_BASE = 40
) (
  input  logic                 clk,
  input  logic                 nrst,
  dec_unbinder_pack_4_if.slave bus
);

  localparam int SW = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;

  typedef logic [0:NUM_CH-1][HV_DIM-1:0] hv_arr_t;
  typedef enum logic [1:0] {IDLE, UNBIND, DONE} state_t;

  // Shift reduced mod HV_DIM at elaboration: S=0 or S=HV_DIM is identity.
  function automatic logic [SW-1:0] shamt(input int i);
    return SW'(dec_unbinder_pkg::SHIFTS[SHIFT_BASE+i] % HV_DIM);
  endfunction

  // Low half of {v,v}>>s gives out[b] = v[(b+s) mod HV_DIM].
  function automatic logic [HV_DIM-1:0] rotr(
    input logic [HV_DIM-1:0] v,
    input logic [SW-1:0]     s
  );
    logic [2*HV_DIM-1:0] w;
    w = {v, v} >> s;
    return w[HV_DIM-1:0];
  endfunction

  state_t  state, state_n;
  hv_arr_t cap;
  hv_arr_t lvl;
  logic    accept;
  logic    last;

  // DONE re-accepts a start so runs can go back to back.
  assign accept = bus.start_decoding &&
                  (state == IDLE || state == DONE);

`ifdef DEC_UNBINDER_PARALLEL_EN

  assign last = 1'b1;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cap <= '0;
      lvl <= '0;
    end else if (accept) begin
      cap <= bus.shifted_hv;
    end else if (state == UNBIND) begin
      for (int i = 0; i < NUM_CH; i++)
        lvl[i] <= rotr(cap[i], shamt(i));
    end
  end

`else

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CW-1:0]     ch;
  logic [HV_DIM-1:0] sel_hv;
  logic [SW-1:0]     sel_s;
  logic [HV_DIM-1:0] rot_hv;

  assign last = (ch == CW'(NUM_CH - 1));

  // One shared rotator fed by a channel mux.
  always_comb begin
    sel_hv = '0;
    sel_s  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == CW'(i)) begin
        sel_hv = cap[i];
        sel_s  = shamt(i);
      end
    end
  end

  assign rot_hv = rotr(sel_hv, sel_s);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cap <= '0;
      lvl <= '0;
      ch  <= '0;
    end else if (accept) begin
      cap <= bus.shifted_hv;
      ch  <= '0;
    end else if (state == UNBIND) begin
      for (int i = 0; i < NUM_CH; i++)
        if (ch == CW'(i)) lvl[i] <= rot_hv;
      ch <= last ? '0 : ch + 1'b1;
    end
  end

`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = IDLE;
    unique case (1'b1)
      accept:          state_n = UNBIND;
      state == UNBIND: state_n = last ? DONE : UNBIND;
      default:         state_n = IDLE;
    endcase
  end

  assign bus.level_hv = lvl;
  assign bus.busy     = (state == UNBIND);
  assign bus.done     = (state == DONE);

endmodule
